// File: rtl/output_packer.sv
// output_packer: packs core bytes into 16-bit words and buffers them in a FWFT FIFO for the host side
module output_packer #(
  parameter int DEPTH = 16,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               din,
  input  logic                     wr_en,
  input  logic                     eop,
  output logic                     full,
  input  logic                     rd_en,
  output logic [15:0]              dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     half
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    pack;
  logic [CW-1:0] cnt_nxt;
  logic [15:0]   push_word;
  logic          wr_acc, push, pop;
  // accept/push/pop decode and the word formed from the held byte or the pad
  always_comb begin
    wr_acc    = wr_en & ~full;
    push      = wr_acc & (half | eop);
    pop       = rd_en & ~empty;
    push_word = half ? {din, pack} : {PAD_BYTE, din};
    cnt_nxt   = word_count + CW'(push) - CW'(pop);
  end
  // pack register, pointers and registered occupancy flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack       <= '0;
      half       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
    end else begin
      if (wr_acc) half <= ~half & ~eop;
      if (wr_acc & ~half & ~eop) pack <= din;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      word_count <= cnt_nxt;
      empty      <= cnt_nxt == '0;
      full       <= cnt_nxt == FULL_CNT;
    end
  end
  // word storage written on push; read asynchronously at the head
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end
  assign dout = mem[rd_ptr];
endmodule

// File: tb/tb_output_packer.sv
// tb_output_packer: directed self-checking bench for output_packer
module tb_output_packer;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] din = '0;
  logic wr_en = 1'b0, eop = 1'b0, rd_en = 1'b0;
  logic full, empty, half, full2, empty2, half2;
  logic [15:0] dout, dout2;
  logic [4:0] word_count, word_count2;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  output_packer #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .eop(eop), .full(full),
    .rd_en(rd_en), .dout(dout), .empty(empty), .word_count(word_count), .half(half));

  output_packer #(.DEPTH(16), .PAD_BYTE(8'hFF)) dut_ff (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .eop(eop), .full(full2),
    .rd_en(rd_en), .dout(dout2), .empty(empty2), .word_count(word_count2), .half(half2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b, input logic e);
    @(negedge clk);
    din = b; wr_en = 1'b1; eop = e;
    @(posedge clk); #1;
    wr_en = 1'b0; eop = 1'b0;
  endtask

  task automatic rd();
    @(negedge clk);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  initial begin
    int err, popped, k;
    logic [7:0] lo, hi;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_half", half, 0);
    check("rst_wc", word_count, 0);
    // pair with eop on second byte
    wr(8'h11, 1'b0);
    check("t1_half", half, 1);
    check("t1_empty_mid", empty, 1);
    wr(8'h22, 1'b1);
    check("t1_empty", empty, 0);
    check("t1_dout", dout, 16'h2211);
    check("t1_wc", word_count, 1);
    check("t1_half0", half, 0);
    rd();
    check("t1_drained", empty, 1);
    // odd trailing byte padded
    wr(8'h33, 1'b1);
    check("t2_dout", dout, 16'h0033);
    check("t2_dout_ff", dout2, 16'hFF33);
    check("t2_half", half, 0);
    rd();
    // fill to full
    for (int i = 1; i <= 32; i++) wr(8'(i), 1'b0);
    check("t3_full", full, 1);
    check("t3_wc", word_count, 16);
    wr(8'hAA, 1'b0);
    wr(8'hBB, 1'b0);
    check("t3_drop_half", half, 0);
    check("t3_drop_wc", word_count, 16);
    check("t3_head", dout, 16'h0201);
    // simultaneous pop and write while full
    @(negedge clk);
    din = 8'hCC; wr_en = 1'b1; eop = 1'b0; rd_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check("t4_wc", word_count, 15);
    check("t4_half", half, 0);
    check("t4_full", full, 0);
    wr(8'hCC, 1'b1);
    check("t4_wc_after", word_count, 16);
    for (int j = 1; j <= 15; j++) begin
      check($sformatf("t3_word%0d", j), dout, {8'(2*j+2), 8'(2*j+1)});
      rd();
    end
    check("t4_last", dout, 16'h00CC);
    rd();
    check("t3_empty", empty, 1);
    // steady state streaming with wrap
    err = 0; popped = 0; k = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      din = 8'(i); wr_en = 1'b1; eop = 1'b0; rd_en = !empty;
      if (!empty) begin
        lo = 8'(2*k); hi = 8'(2*k+1);
        if (dout !== {hi, lo}) err++;
        k++; popped++;
      end
      @(posedge clk); #1;
      if (word_count > 1) err++;
    end
    wr_en = 1'b0;
    for (int g = 0; g < 4 && !empty; g++) begin
      lo = 8'(2*k); hi = 8'(2*k+1);
      if (dout !== {hi, lo}) err++;
      k++; popped++;
      rd();
    end
    check("t5_errors", err, 0);
    check("t5_popped", popped, 60);
    check("t5_empty", empty, 1);
    // reset mid-pair
    wr(8'h44, 1'b0);
    check("t6_half", half, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check("t6_rst_half", half, 0);
    check("t6_rst_empty", empty, 1);
    wr(8'h55, 1'b0);
    wr(8'h66, 1'b0);
    check("t6_wc", word_count, 1);
    check("t6_dout", dout, 16'h6655);
    rd();
    check("t6_empty", empty, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/output_packer.md
Name: output_packer

Overview:
- Core-to-host direction of the inouttraffic byte path.
- Accepts a stream of 8-bit bytes from the core side with packet boundaries, packs byte pairs into 16-bit words, and buffers them in an internal single-clock FIFO.
- The host side reads words through a first-word-fall-through interface that feeds the 16-bit USB output logic.
- Odd-length packets are padded to a whole word at end-of-packet.

Parameters:
DEPTH, 16, word buffer depth; power of 2, minimum 4
PAD_BYTE, 8'h00, filler byte for the upper half of an odd trailing word

Ports:
clk  input  1  single clock for both sides
rst  input  1  asynchronous reset, active-high
din  input  8  byte from core
wr_en  input  1  byte write strobe; accepted only when full=0
eop  input  1  last byte of packet; qualified by an accepted wr_en
full  output  1  buffer holds DEPTH words; byte writes are dropped
rd_en  input  1  pop current word; ignored when empty=1
dout  output  16  current head word (FWFT); valid when empty=0
empty  output  1  no complete word buffered
word_count  output  $clog2(DEPTH)+1  number of complete words buffered
half  output  1  one byte is held in the pack register awaiting its pair

Behaviour:
- Reset state (async assert, clocked deassert): pointers=0, word_count=0, empty=1, full=0, half=0, pack register=0. dout is don't-care while empty=1.
- Byte order: the first byte of a pair goes to dout[7:0]; the second byte goes to dout[15:8].
- Accepted write is wr_en & ~full.
  - half=0, eop=0: latch din into the pack register; half<=1; no word is pushed.
  - half=0, eop=1: push {PAD_BYTE, din}; half stays 0.
  - half=1 (eop 0 or 1): push {din, pack}; half<=0. An eop on the second byte of a pair adds no extra word.
- Write while full=1: dropped. No change to half, the pack register or the buffer.
- full is computed from the registered word_count (full = word_count==DEPTH), so a simultaneous rd_en does not unblock a write in the same cycle.
- Accepted read is rd_en & ~empty: rd_ptr advances and the next word appears on dout in the same cycle after the edge.
- Read latency: a word pushed at edge N gives empty=0 and valid dout after edge N (one-cycle write-to-visibility).
- Empty FIFO: a word pushed at edge N cannot be popped before edge N+1; no combinational write-through.
- Pointers are log2(DEPTH) bits wide and wrap naturally modulo DEPTH. word_count is updated as:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop
- empty = (word_count==0); full = (word_count==DEPTH); both are driven from registers, not from combinational decode of inputs.
- Storage: distributed RAM, written synchronously, read asynchronously at rd_ptr.
- Reset mid-packet: a held half byte is discarded and buffered words are lost. The next byte after reset starts a fresh pair.
- eop asserted without an accepted wr_en has no effect.

Test Plan:
1. Reset, then write bytes 8'h11, 8'h22 with eop on 8'h22 -> one word dout=16'h2211, word_count=1, half=0; empty falls the cycle after the second write.
2. Write 8'h33 with eop=1 from half=0 -> dout=16'h0033 (PAD_BYTE default); with PAD_BYTE=8'hFF -> 16'hFF33.
3. Write 2*DEPTH bytes with rd_en=0 -> full=1 at word_count=16. Then write 8'hAA, 8'hBB -> both dropped, half stays 0. Pop all words -> order preserved, last word matches byte pair 31/32.
4. Hold full=1, assert rd_en and wr_en in the same cycle -> the pop occurs, the write is dropped, word_count=15; the next cycle's write is accepted.
5. Steady state: continuous byte writes plus rd_en=1 whenever empty=0 -> word_count never exceeds 1, no word lost, pointer wrap exercised over more than 3*DEPTH words.
6. Write 8'h44 (half=1), assert rst for 1 cycle, then write 8'h55, 8'h66 -> the sole word is 16'h6655; byte 8'h44 never appears.
